ps2_key_stream_decoder: RTL and testbench
=========================================

// Module: ps2_key_stream_decoder
// PURPOSE
//  Sequential successor to the combinational nibble-pair letter lookup. Consumes the raw PS/2 Set-2 scancode byte stream,
//  tracks E0 (extended) and F0 (break) prefixes, maps key presses to letter codes (a=0..z=25, ENTR=31),
//  suppresses typematic repeats, and buffers codes in a FIFO with a valid/ready output handshake.
//  Sits between the PS/2 byte receiver and the game/display logic.
// PARAMETERS
//  DEPTH      4  output FIFO entries; power of two, 2..16
//  CODE_W     5  output code width; >=5, codes zero-extended
//  SUPPRESS_REPEAT  1  1 = drop a make code equal to the held key until its break arrives
// PORTS
//  clk          in   1       system clock; single clock domain
//  rst_n        in   1       asynchronous, active-low reset
//  scan_valid   in   1       one-cycle strobe: scan_byte holds a complete received byte
//  scan_byte    in   8       Set-2 scancode byte
//  key_valid    out  1       FIFO non-empty; key_code valid
//  key_ready    in   1       consumer accepts key_code when key_valid&key_ready
//  key_code     out  CODE_W  head-of-FIFO code
//  fifo_count   out  $clog2(DEPTH)+1  entries held
//  overflow     out  1       sticky: a code was dropped because the FIFO was full
//  clr_overflow in   1       synchronous clear of overflow
// BEHAVIOUR
//  - Reset: FSM=IDLE, FIFO empty, key_valid=0, key_code=0, fifo_count=0, overflow=0, held key = none.
//  - FSM (advances only on scan_valid): IDLE --E0--> EXT; IDLE --F0--> BRK; EXT --F0--> EXT_BRK;
//    IDLE/EXT with any other byte: make event, return to IDLE; BRK/EXT_BRK with any byte: break event, return to IDLE.
//  - Map (non-extended): 15 q,1D w,1C a,1B s,1A z,24 e,2D r,2C t,23 d,2B f,22 x,21 c,2A v,35 y,3C u,34 g,
//    33 h,3B j,32 b,31 n,3A m,43 i,44 o,4D p,42 k,4B l,5A ENTR. Extended: only E0 5A (keypad Enter) -> ENTR.
//    Every other byte (incl. AA, FA, EE, E1 sequences) maps to "none": no push, held key unchanged, FSM still advances.
//  - Make of mapped key: if SUPPRESS_REPEAT and code==held -> dropped; else push, held<=code.
//  - Break of mapped key: if code==held, held<=none. Never pushes.
//  - Latency: code is on key_code with key_valid=1 one cycle after the scan_valid cycle of its final byte (FIFO empty).
//  - FIFO: pop on key_valid&key_ready; push & pop same cycle when full -> both succeed, count unchanged.
//    Push when full without pop -> code dropped, overflow<=1 (held still updated). clr_overflow and a new drop in
//    the same cycle -> overflow stays 1. Read/write pointers wrap modulo DEPTH.
//  - key_code/key_valid held stable while key_valid&!key_ready.
//  - rst_n assertion mid-sequence (e.g. after F0) discards prefix state and FIFO contents immediately.
// CONFIGURATION
//  BACKSPACE_EN defined: non-extended 66 (Backspace) maps to BKSP = 30, same make/break/repeat rules as letters.
//  Not defined: 66 maps to "none" and is ignored; code 30 never appears.
// STRUCTURE
//  Package keycode_pkg: letter code constants a..z, ENTR=31, BKSP=30, KEY_NONE sentinel, prefix constants
//  SC_EXT=8'hE0, SC_BRK=8'hF0, FSM state typedef {IDLE,EXT,BRK,EXT_BRK}, Set-2 -> code lookup function.
//  One sub-module: key_fifo (synchronous FIFO, DEPTH x CODE_W, count/full/empty, async active-low reset).
// TESTING
//  1 bytes 1C, F0 1C -> one code 0 (a) out; held cleared; fifo_count back to 0 after pop.
//  2 bytes 15,15,15,F0 15,15 with SUPPRESS_REPEAT=1 -> exactly two q (16) codes; with 0 -> four.
//  3 key_ready=0, DEPTH=4, press a,b,c,d,e (with breaks) -> count 4, overflow=1, then pop order 0,1,2,3.
//  4 E0 5A -> 31; E0 F0 5A -> no push; 5A -> 31; E0 75 (arrow) -> nothing.
//  5 66 -> 30 with BACKSPACE_EN, no output without; full FIFO + simultaneous push/pop -> count stays 4.
//  6 F0 then rst_n low mid-stream, release, byte 1D -> w (22) pushed as a make, not a break.

Source files
------------

// File: rtl/ps2_key_stream_decoder_pkg.sv
// rtl/ps2_key_stream_decoder_pkg.sv - keycode_pkg: letter codes, scancode prefixes, FSM states, Set-2 lookup
// Purpose : shared constants and the Set-2 -> letter code lookup for the PS/2 key stream decoder.
// Ports   : none (package).
// Config  : BACKSPACE_EN defined -> non-extended 8'h66 maps to KEY_BKSP (30); otherwise ignored.
package keycode_pkg;

   typedef logic [4:0] code_t;

   localparam code_t KEY_A = 5'd0,  KEY_B = 5'd1,  KEY_C = 5'd2,  KEY_D = 5'd3,  KEY_E = 5'd4;
   localparam code_t KEY_F = 5'd5,  KEY_G = 5'd6,  KEY_H = 5'd7,  KEY_I = 5'd8,  KEY_J = 5'd9;
   localparam code_t KEY_K = 5'd10, KEY_L = 5'd11, KEY_M = 5'd12, KEY_N = 5'd13, KEY_O = 5'd14;
   localparam code_t KEY_P = 5'd15, KEY_Q = 5'd16, KEY_R = 5'd17, KEY_S = 5'd18, KEY_T = 5'd19;
   localparam code_t KEY_U = 5'd20, KEY_V = 5'd21, KEY_W = 5'd22, KEY_X = 5'd23, KEY_Y = 5'd24;
   localparam code_t KEY_Z = 5'd25;
   localparam code_t KEY_BKSP = 5'd30;
   localparam code_t KEY_ENTR = 5'd31;
   // Code 27 is never produced, so it doubles as "no key" for lookups and the held-key register.
   localparam code_t KEY_NONE = 5'd27;

   localparam logic [7:0] SC_EXT = 8'hE0;
   localparam logic [7:0] SC_BRK = 8'hF0;

   typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} ps2_state_t;

   function automatic code_t scan_to_code(input logic [7:0] sc, input logic ext);
      code_t c;
      c = KEY_NONE;
      if (ext) begin
         if (sc == 8'h5A) c = KEY_ENTR;
      end else begin
         case (sc)
            8'h15: c = KEY_Q;  8'h1D: c = KEY_W;  8'h1C: c = KEY_A;  8'h1B: c = KEY_S;
            8'h1A: c = KEY_Z;  8'h24: c = KEY_E;  8'h2D: c = KEY_R;  8'h2C: c = KEY_T;
            8'h23: c = KEY_D;  8'h2B: c = KEY_F;  8'h22: c = KEY_X;  8'h21: c = KEY_C;
            8'h2A: c = KEY_V;  8'h35: c = KEY_Y;  8'h3C: c = KEY_U;  8'h34: c = KEY_G;
            8'h33: c = KEY_H;  8'h3B: c = KEY_J;  8'h32: c = KEY_B;  8'h31: c = KEY_N;
            8'h3A: c = KEY_M;  8'h43: c = KEY_I;  8'h44: c = KEY_O;  8'h4D: c = KEY_P;
            8'h42: c = KEY_K;  8'h4B: c = KEY_L;  8'h5A: c = KEY_ENTR;
`ifdef BACKSPACE_EN
            8'h66: c = KEY_BKSP;
`endif
            default: c = KEY_NONE;
         endcase
      end
      return c;
   endfunction

endpackage

// File: rtl/ps2_key_stream_decoder_if.sv
// rtl/ps2_key_stream_decoder_if.sv - scancode input strobe and key code output handshake
// Purpose : bundles the scancode byte strobe and the key_valid/key_ready code stream.
// Signals : scan_valid, scan_byte (byte receiver -> decoder); key_valid, key_code (decoder -> consumer);
//           key_ready (consumer -> decoder).
// Modports: slave = decoder side, master = receiver/consumer side.
interface ps2_key_stream_decoder_if #(parameter int CODE_W = 5);
   logic              scan_valid;
   logic [7:0]        scan_byte;
   logic              key_valid;
   logic              key_ready;
   logic [CODE_W-1:0] key_code;

   modport master (output scan_valid, output scan_byte, output key_ready,
                   input key_valid, input key_code);
   modport slave  (input scan_valid, input scan_byte, input key_ready,
                   output key_valid, output key_code);
endinterface

// File: rtl/ps2_key_stream_decoder_key_fifo.sv
// rtl/ps2_key_stream_decoder_key_fifo.sv - key_fifo: synchronous DEPTH x W code FIFO
// Purpose : buffers decoded key codes; push while full succeeds only with a same-cycle pop.
// Ports   : clk, rst_n (async active-low); push/push_data in; pop in, pop_data out (0 when empty);
//           count, full, empty out.
module key_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 5
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [W-1:0]             push_data,
   input  logic                     pop,
   output logic [W-1:0]             pop_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          push_ok, pop_ok;

   assign full     = (count == (AW+1)'(DEPTH));
   assign empty    = (count == '0);
   assign pop_ok   = pop && !empty;
   assign push_ok  = push && (!full || pop_ok);
   assign pop_data = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_data;
   end

   // Pointers are exactly AW bits wide, so DEPTH being a power of two makes them wrap naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/ps2_key_stream_decoder.sv
// rtl/ps2_key_stream_decoder.sv - PS/2 Set-2 scancode stream to buffered letter codes
// Purpose : tracks E0/F0 prefixes, maps makes to letter codes (a=0..z=25, ENTR=31), drops typematic
//           repeats of the held key, and queues codes in key_fifo behind a valid/ready handshake.
// Ports   : clk, rst_n (async active-low); kif (slave: scan_valid/scan_byte in, key_valid/key_code out,
//           key_ready in); fifo_count out; overflow out (sticky drop flag); clr_overflow in.
// Config  : BACKSPACE_EN (see keycode_pkg) adds Backspace as code 30.
module ps2_key_stream_decoder
   import keycode_pkg::*;
#(
   parameter int DEPTH           = 4,
   parameter int CODE_W          = 5,
   parameter int SUPPRESS_REPEAT = 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   ps2_key_stream_decoder_if.slave    kif,
   output logic [$clog2(DEPTH):0]     fifo_count,
   output logic                       overflow,
   input  logic                       clr_overflow
);
   ps2_state_t state_q, state_d;
   logic       make_ev, brk_ev, ext_ev;
   code_t      code, held_q;
   logic       mapped, repeat_hit, push, pop, full, empty, drop;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      make_ev = 1'b0;
      brk_ev  = 1'b0;
      ext_ev  = 1'b0;
      if (kif.scan_valid) begin
         case (state_q)
            IDLE: begin
               if (kif.scan_byte == SC_EXT)      state_d = EXT;
               else if (kif.scan_byte == SC_BRK) state_d = BRK;
               else begin
                  make_ev = 1'b1;
                  state_d = IDLE;
               end
            end
            EXT: begin
               if (kif.scan_byte == SC_BRK) state_d = EXT_BRK;
               else begin
                  make_ev = 1'b1;
                  ext_ev  = 1'b1;
                  state_d = IDLE;
               end
            end
            BRK: begin
               brk_ev  = 1'b1;
               state_d = IDLE;
            end
            EXT_BRK: begin
               brk_ev  = 1'b1;
               ext_ev  = 1'b1;
               state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign code       = scan_to_code(kif.scan_byte, ext_ev);
   assign mapped     = (code != KEY_NONE);
   assign repeat_hit = (SUPPRESS_REPEAT != 0) && (code == held_q);
   assign push       = make_ev && mapped && !repeat_hit;
   assign pop        = kif.key_valid && kif.key_ready;
   assign drop       = push && full && !pop;

   // Held key follows every accepted make even when the FIFO drops the code, so a later
   // repeat of that key is still treated as a repeat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         held_q   <= KEY_NONE;
         overflow <= 1'b0;
      end else begin
         if (push)                                  held_q <= code;
         else if (brk_ev && mapped && code == held_q) held_q <= KEY_NONE;
         if (drop)              overflow <= 1'b1;
         else if (clr_overflow) overflow <= 1'b0;
      end
   end

   key_fifo #(.DEPTH(DEPTH), .W(CODE_W)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (CODE_W'(code)),
      .pop       (pop),
      .pop_data  (kif.key_code),
      .count     (fifo_count),
      .full      (full),
      .empty     (empty)
   );

   assign kif.key_valid = !empty;
endmodule

// File: tb/tb_ps2_key_stream_decoder.sv
// tb/tb_ps2_key_stream_decoder.sv - directed self-checking bench for ps2_key_stream_decoder
module tb_ps2_key_stream_decoder;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       scan_valid = 1'b0;
   logic [7:0] scan_byte = 8'h00;
   logic       key_ready = 1'b0;
   logic       clr = 1'b0;
   logic [2:0] cnt0, cnt1;
   logic       ovf0, ovf1;
   int         total = 0;
   int         bad = 0;

   always #5 clk = ~clk;

   ps2_key_stream_decoder_if #(.CODE_W(5)) if0 ();
   ps2_key_stream_decoder_if #(.CODE_W(5)) if1 ();

   assign if0.scan_valid = scan_valid;
   assign if0.scan_byte  = scan_byte;
   assign if0.key_ready  = key_ready;
   assign if1.scan_valid = scan_valid;
   assign if1.scan_byte  = scan_byte;
   assign if1.key_ready  = 1'b0;

   ps2_key_stream_decoder #(.DEPTH(4), .CODE_W(5), .SUPPRESS_REPEAT(1)) dut (
      .clk(clk), .rst_n(rst_n), .kif(if0.slave),
      .fifo_count(cnt0), .overflow(ovf0), .clr_overflow(clr));

   ps2_key_stream_decoder #(.DEPTH(4), .CODE_W(5), .SUPPRESS_REPEAT(0)) dut_norep (
      .clk(clk), .rst_n(rst_n), .kif(if1.slave),
      .fifo_count(cnt1), .overflow(ovf1), .clr_overflow(clr));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic send(input logic [7:0] b);
      @(negedge clk);
      scan_valid = 1'b1;
      scan_byte  = b;
      @(negedge clk);
      scan_valid = 1'b0;
   endtask

   // Checks the head code, then pops it with a one-cycle ready pulse.
   task automatic pop_chk(input string tag, input logic [4:0] exp);
      chk({tag, "_valid"}, {31'd0, if0.key_valid}, 32'd1);
      chk({tag, "_code"}, {27'd0, if0.key_code}, {27'd0, exp});
      key_ready = 1'b1;
      @(negedge clk);
      key_ready = 1'b0;
   endtask

   initial begin
      do_reset();
      chk("rst_valid", {31'd0, if0.key_valid}, 32'd0);
      chk("rst_code", {27'd0, if0.key_code}, 32'd0);
      chk("rst_count", {29'd0, cnt0}, 32'd0);
      chk("rst_ovf", {31'd0, ovf0}, 32'd0);

      // 1: a make, one-cycle latency, break, pop, held cleared
      send(8'h1C);
      chk("t1_latency_valid", {31'd0, if0.key_valid}, 32'd1);
      chk("t1_count", {29'd0, cnt0}, 32'd1);
      send(8'hF0); send(8'h1C);
      chk("t1_break_nopush", {29'd0, cnt0}, 32'd1);
      pop_chk("t1_pop", 5'd0);
      chk("t1_count_after_pop", {29'd0, cnt0}, 32'd0);
      send(8'h1C);
      chk("t1_held_cleared", {29'd0, cnt0}, 32'd1);
      pop_chk("t1_pop2", 5'd0);

      // 2: typematic repeat suppression vs. no suppression
      do_reset();
      send(8'h15); send(8'h15); send(8'h15); send(8'hF0); send(8'h15); send(8'h15);
      chk("t2_rep_count", {29'd0, cnt0}, 32'd2);
      chk("t2_norep_count", {29'd0, cnt1}, 32'd4);
      chk("t2_norep_ovf", {31'd0, ovf1}, 32'd0);
      pop_chk("t2_q0", 5'd16);
      pop_chk("t2_q1", 5'd16);
      chk("t2_empty", {31'd0, if0.key_valid}, 32'd0);

      // 3: overflow, clear-vs-drop priority, full push+pop, pop order
      do_reset();
      send(8'h1C); send(8'hF0); send(8'h1C);
      send(8'h32); send(8'hF0); send(8'h32);
      send(8'h21); send(8'hF0); send(8'h21);
      send(8'h23); send(8'hF0); send(8'h23);
      send(8'h24); send(8'hF0); send(8'h24);
      chk("t3_full_count", {29'd0, cnt0}, 32'd4);
      chk("t3_ovf", {31'd0, ovf0}, 32'd1);
      @(negedge clk);
      scan_valid = 1'b1; scan_byte = 8'h2B; clr = 1'b1;
      @(negedge clk);
      scan_valid = 1'b0; clr = 1'b0;
      chk("t3_clr_with_drop", {31'd0, ovf0}, 32'd1);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      chk("t3_clr", {31'd0, ovf0}, 32'd0);
      send(8'hF0); send(8'h2B);
      chk("t3_head_a", {27'd0, if0.key_code}, 32'd0);
      scan_valid = 1'b1; scan_byte = 8'h1C; key_ready = 1'b1;
      @(negedge clk);
      scan_valid = 1'b0; key_ready = 1'b0;
      chk("t3_pushpop_count", {29'd0, cnt0}, 32'd4);
      chk("t3_pushpop_ovf", {31'd0, ovf0}, 32'd0);
      pop_chk("t3_b", 5'd1);
      pop_chk("t3_c", 5'd2);
      pop_chk("t3_d", 5'd3);
      pop_chk("t3_a_wrap", 5'd0);
      chk("t3_empty", {29'd0, cnt0}, 32'd0);

      // 4: extended Enter, extended break, plain Enter, unmapped extended/other bytes
      do_reset();
      send(8'hE0); send(8'h5A);
      pop_chk("t4_kp_enter", 5'd31);
      send(8'hE0); send(8'hF0); send(8'h5A);
      chk("t4_ext_break_nopush", {29'd0, cnt0}, 32'd0);
      send(8'h5A);
      pop_chk("t4_enter", 5'd31);
      send(8'hF0); send(8'h5A);
      send(8'hE0); send(8'h75);
      send(8'hE0); send(8'h1C);
      send(8'hAA);
      chk("t4_unmapped", {29'd0, cnt0}, 32'd0);

      // 5: Backspace depends on build option
      send(8'h66);
`ifdef BACKSPACE_EN
      pop_chk("t5_bksp", 5'd30);
`else
      chk("t5_no_bksp", {29'd0, cnt0}, 32'd0);
`endif
      send(8'hF0); send(8'h66);
      chk("t5_break_nopush", {29'd0, cnt0}, 32'd0);

      // 6: reset mid-sequence discards FIFO and F0 prefix
      send(8'h1C);
      send(8'hF0);
      #2 rst_n = 1'b0;
      #1 chk("t6_async_clear", {29'd0, cnt0}, 32'd0);
      chk("t6_async_valid", {31'd0, if0.key_valid}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      send(8'h1D);
      chk("t6_make_count", {29'd0, cnt0}, 32'd1);
      pop_chk("t6_w", 5'd22);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
